// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg -- shared constants for the pipelined ALU.
//   ALU_OP_*  : 3-bit operation codes presented on in_op.
//   FLAG_*    : bit positions inside the 4-bit flag vector {N, Z, C, V}.
package alu_pipe_pkg;

  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  localparam logic [2:0] ALU_OP_SUB = 3'b001;
  localparam logic [2:0] ALU_OP_AND = 3'b010;
  localparam logic [2:0] ALU_OP_OR  = 3'b011;
  localparam logic [2:0] ALU_OP_XOR = 3'b100;
  localparam logic [2:0] ALU_OP_NOT = 3'b101;
  localparam logic [2:0] ALU_OP_SHL = 3'b110;
  localparam logic [2:0] ALU_OP_SHR = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// alu_core -- purely combinational WIDTH-bit ALU.
//   op     : operation code (alu_pipe_pkg::ALU_OP_*)
//   a, b   : operands
//   cin    : carry-in for ADD, borrow-in for SUB; ignored by other ops
//   result : WIDTH-bit result
//   flags  : {N, Z, C, V}; C is carry-out (ADD), borrow (SUB) or the bit
//            shifted out (SHL/SHR); V is signed overflow for ADD/SUB only
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  // Two's-complement overflow from operand/result sign bits.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] res;
  logic             c;
  logic             v;

  always_comb begin
    ext = '0;
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      ALU_OP_ADD: begin
        ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        res = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = add_ovf(a[WIDTH-1], b[WIDTH-1], res[WIDTH-1]);
      end
      ALU_OP_SUB: begin
        // The extra top bit goes high exactly when a < b + cin (unsigned).
        ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        res = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = sub_ovf(a[WIDTH-1], b[WIDTH-1], res[WIDTH-1]);
      end
      ALU_OP_AND: res = a & b;
      ALU_OP_OR:  res = a | b;
      ALU_OP_XOR: res = a ^ b;
      ALU_OP_NOT: res = ~a;
      ALU_OP_SHL: begin
        res = {a[WIDTH-2:0], 1'b0};
        c   = a[WIDTH-1];
      end
      ALU_OP_SHR: begin
        res = {1'b0, a[WIDTH-1:1]};
        c   = a[0];
      end
      default: res = '0;
    endcase
  end

  always_comb begin
    result         = res;
    flags          = '0;
    flags[FLAG_N]  = res[WIDTH-1];
    flags[FLAG_Z]  = (res == '0);
    flags[FLAG_C]  = c;
    flags[FLAG_V]  = v;
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe -- two-stage pipelined ALU with valid/ready on both sides.
//   clk, rst       : clock, synchronous active-high reset
//   in_valid/ready : operand beat handshake (in_op, in_a, in_b, in_chain)
//   out_valid/ready: result beat handshake (out_result, out_flags {N,Z,C,V})
// Optional feature macro: ALU_PIPE_CARRY_CHAIN_EN. When defined, a carry
// register captures C from every ADD/SUB and in_chain feeds it back as the
// carry/borrow-in, so wide add/sub can be streamed limb by limb. When
// undefined, in_chain is ignored and carry-in is always 0.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags
);

  logic             vld_p1;
  logic [2:0]       op_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic             vld_p2;
  logic [WIDTH-1:0] result_p2;
  logic [3:0]       flags_p2;

  logic             s1_load;
  logic             s2_load;
  logic             cin;
  logic [WIDTH-1:0] core_result;
  logic [3:0]       core_flags;

  assign s2_load  = vld_p1 && (!vld_p2 || out_ready);
  assign in_ready = !rst && (!vld_p1 || s2_load);
  assign s1_load  = in_valid && in_ready;

  // ---- Stage 1: operand capture ----
  always_ff @(posedge clk) begin
    if (rst)          vld_p1 <= 1'b0;
    else if (s1_load) vld_p1 <= 1'b1;
    else if (s2_load) vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      op_p1 <= in_op;
      a_p1  <= in_a;
      b_p1  <= in_b;
    end
  end

`ifdef ALU_PIPE_CARRY_CHAIN_EN
  logic chain_p1;
  logic carry_q;

  always_ff @(posedge clk) begin
    if (s1_load) chain_p1 <= in_chain;
  end

  // Beats retire in order, so the carry seen here always belongs to the
  // most recent ADD/SUB ahead of this beat.
  always_ff @(posedge clk) begin
    if (rst)
      carry_q <= 1'b0;
    else if (s2_load && (op_p1 == ALU_OP_ADD || op_p1 == ALU_OP_SUB))
      carry_q <= core_flags[FLAG_C];
  end

  assign cin = chain_p1 && carry_q;
`else
  logic unused_chain;
  assign unused_chain = in_chain;
  assign cin          = 1'b0;
`endif

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op    (op_p1),
    .a     (a_p1),
    .b     (b_p1),
    .cin   (cin),
    .result(core_result),
    .flags (core_flags)
  );

  // ---- Stage 2: result register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      flags_p2  <= '0;
    end else if (s2_load) begin
      vld_p2    <= 1'b1;
      result_p2 <= core_result;
      flags_p2  <= core_flags;
    end else if (out_ready) begin
      vld_p2    <= 1'b0;
    end
  end

  assign out_valid  = vld_p2;
  assign out_result = result_p2;
  assign out_flags  = flags_p2;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe -- table-driven, scoreboarded bench for alu_pipe (WIDTH=8).
// Expected chained-add results follow ALU_PIPE_CARRY_CHAIN_EN.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_chain;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [3:0] out_flags;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_chain  (in_chain),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flags (out_flags)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       chain;
    logic [7:0] r;
    logic [3:0] f;
  } vec_t;

  typedef struct {
    logic [7:0] r;
    logic [3:0] f;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[16];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one beat and wait (bounded) for its acceptance; the expected
  // result is queued at the point of acceptance.
  task automatic send(input vec_t v);
    bit done = 0;
    in_valid = 1'b1;
    in_op    = v.op;
    in_a     = v.a;
    in_b     = v.b;
    in_chain = v.chain;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_t e;
        e.r = v.r;
        e.f = v.f;
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      $display("FAIL send_timeout: in_ready stayed %0b, expected 1", in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++) @(posedge clk);
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  // Output monitor: pops the scoreboard on each transfer and checks that a
  // stalled result holds steady.
  logic        held_v = 1'b0;
  logic [11:0] held   = '0;

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (held_v) check("stall_stable", {out_flags, out_result}, held);
      if (out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got %0h expected none", out_result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", out_result, e.r);
          check("flags", out_flags, e.f);
        end
      end
      held_v = !out_ready;
      held   = {out_flags, out_result};
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0]  = '{ALU_OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1001};
    vecs[1]  = '{ALU_OP_SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b1010};
    vecs[2]  = '{ALU_OP_SHR, 8'h01, 8'h00, 1'b0, 8'h00, 4'b0110};
    vecs[3]  = '{ALU_OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000};
    vecs[4]  = '{ALU_OP_OR,  8'hF0, 8'h0C, 1'b0, 8'hFC, 4'b1000};
    vecs[5]  = '{ALU_OP_XOR, 8'hFF, 8'hFF, 1'b0, 8'h00, 4'b0100};
    vecs[6]  = '{ALU_OP_NOT, 8'h55, 8'h00, 1'b0, 8'hAA, 4'b1000};
    vecs[7]  = '{ALU_OP_SHL, 8'h81, 8'h00, 1'b0, 8'h02, 4'b0010};
    vecs[8]  = '{ALU_OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0110};
    vecs[9]  = '{ALU_OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b0001};
    vecs[10] = '{ALU_OP_SUB, 8'h05, 8'h03, 1'b0, 8'h02, 4'b0000};
    vecs[11] = '{ALU_OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0110};
`ifdef ALU_PIPE_CARRY_CHAIN_EN
    vecs[12] = '{ALU_OP_ADD, 8'h01, 8'h00, 1'b1, 8'h02, 4'b0000};
`else
    vecs[12] = '{ALU_OP_ADD, 8'h01, 8'h00, 1'b1, 8'h01, 4'b0000};
`endif
    vecs[13] = '{ALU_OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0110};
    vecs[14] = '{ALU_OP_AND, 8'h0F, 8'hF0, 1'b0, 8'h00, 4'b0100};
`ifdef ALU_PIPE_CARRY_CHAIN_EN
    vecs[15] = '{ALU_OP_ADD, 8'h00, 8'h00, 1'b1, 8'h01, 4'b0000};
`else
    vecs[15] = '{ALU_OP_ADD, 8'h00, 8'h00, 1'b1, 8'h00, 4'b0100};
`endif

    // Power-on reset
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    in_chain = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_result", out_result, 0);
    check("rst_flags", out_flags, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Two-edge latency on an empty pipe
    in_valid = 1'b1; in_op = ALU_OP_ADD; in_a = 8'h10; in_b = 8'h20; in_chain = 1'b0;
    @(negedge clk);
    if (in_ready) begin
      exp_t e;
      e.r = 8'h30; e.f = 4'b0000;
      sb.push_back(e);
    end
    check("lat_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_not_yet", out_valid, 0);
    @(posedge clk); #1;
    check("lat_valid", out_valid, 1);
    drain();

    // Table of vectors, back to back at full throughput
    for (int i = 0; i < 16; i++) send(vecs[i]);
    drain();

    // Backpressure: 4 ADDs, downstream stalls 3 cycles after first result
    fork
      begin
        for (int i = 1; i <= 4; i++) begin
          v = '{ALU_OP_ADD, 8'(i), 8'(i), 1'b0, 8'(2 * i), 4'b0000};
          send(v);
        end
      end
      begin
        bit seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
          @(negedge clk);
          seen = out_valid;
        end
        check("bp_first_valid", seen, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready_low", in_ready, 0);
          check("bp_out_valid", out_valid, 1);
          @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight discards them
    out_ready = 1'b0;
    v = '{ALU_OP_ADD, 8'h11, 8'h22, 1'b0, 8'h33, 4'b0000};
    send(v);
    v = '{ALU_OP_ADD, 8'h40, 8'h40, 1'b0, 8'h80, 4'b1001};
    send(v);
    check("mid_pre_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", out_result, 0);
    check("mid_rst_flags", out_flags, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_post_in_ready", in_ready, 1);
    repeat (4) begin
      @(negedge clk);
      check("mid_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;

    // Pipeline still works after the mid-stream reset
    send(vecs[0]);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
